aes_block_tx: RTL

AES_BLOCK_TX -- requirements
Module: aes_block_tx

---
 rtl/aes_uart_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 103 ++++++++++
 rtl/aes_block_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/aes_uart_pkg.sv
// Shared constants and UART frame states for the AES block transmit and receive paths.
package aes_uart_pkg;

  localparam int BYTES_PER_BLOCK = 16;
  localparam int BITS_PER_BYTE   = 8;

  localparam logic [3:0] LAST_BYTE_IDX = 4'(BYTES_PER_BLOCK - 1);
  localparam logic [2:0] LAST_BIT_IDX  = 3'(BITS_PER_BYTE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

  // A block is held as a [127:0] vector with byte 0 in the top eight bits,
  // so byte k lives at bit offset 8*(15-k), which is 8*~k for a 4-bit index.
  function automatic logic [7:0] blockByte(input logic [127:0] blk, input logic [3:0] idx);
    return blk[{~idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART transmitter: start bit, eight data bits LSB first, stop bit.
// A new byte offered during the final stop-bit cycle starts immediately, giving gap-free frames.
module uart_tx_byte
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_byteValid,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_byteDone,
  output logic       o_byteDoneNext
);

  localparam logic [15:0] BIT_END   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] DONE_LEAD = 16'(CLKS_PER_BIT - 2);

  uartState_t  r_state;
  logic [15:0] r_baudCnt;
  logic [2:0]  r_bitIdx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_byteDone;

  logic w_bitEnd;
  logic w_doneNext;

  assign w_bitEnd   = (r_baudCnt == BIT_END);
  assign w_doneNext = (r_state == STOP) && (r_baudCnt == DONE_LEAD);

  assign o_tx           = r_tx;
  assign o_byteDone     = r_byteDone;
  assign o_byteDoneNext = w_doneNext;

  // Frame sequencer: baud counter restarts at each bit boundary; byteDone is raised
  // one cycle early so it is a clean register that is high exactly on the last stop-bit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_baudCnt  <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_byteDone <= 1'b0;
    end else begin
      r_byteDone <= w_doneNext;
      case (r_state)
        IDLE: begin
          r_baudCnt <= '0;
          if (i_byteValid) begin
            r_shift <= i_byte;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bitEnd) begin
            r_baudCnt <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bitIdx  <= '0;
            r_state   <= DATA;
          end else begin
            r_baudCnt <= r_baudCnt + 16'd1;
          end
        end
        DATA: begin
          if (w_bitEnd) begin
            r_baudCnt <= '0;
            r_bitIdx  <= r_bitIdx + 3'd1;
            if (r_bitIdx == LAST_BIT_IDX) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baudCnt <= r_baudCnt + 16'd1;
          end
        end
        STOP: begin
          if (w_bitEnd) begin
            r_baudCnt <= '0;
            if (i_byteValid) begin
              r_shift <= i_byte;
              r_tx    <= 1'b0;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baudCnt <= r_baudCnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aes_block_tx.sv
// Serializes 128-bit ciphertext blocks as sixteen back-to-back UART frames,
// with a one-deep pending slot so a block can arrive while another is on the line.
module aes_block_tx
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] encrypted_data,
  input  logic         encrypted_data_state,
  output logic         tx,
  output logic         busy,
  output logic         tx_done,
  output logic         overrun
);

  logic [127:0] r_block;
  logic [127:0] r_pend;
  logic         r_pendValid;
  logic         r_active;
  logic [3:0]   r_byteIdx;
  logic         r_busy;
  logic         r_txDone;
  logic         r_overrun;

  logic [127:0] w_inBlock;
  logic         w_byteValid;
  logic [7:0]   w_byteData;
  logic         w_byteDone;
  logic         w_byteDoneNext;
  logic         w_lastByte;
  logic         w_blockEnd;

  // Port bit 0 (MSB of byte 0) lands in bit 127 of the internal descending vector.
  assign w_inBlock  = encrypted_data;
  assign w_lastByte = (r_byteIdx == LAST_BYTE_IDX);
  assign w_blockEnd = r_active && w_byteDone && w_lastByte;

  assign busy    = r_busy;
  assign tx_done = r_txDone;
  assign overrun = r_overrun;

  // Choose the byte offered to the framer: a fresh block when idle, the next byte of the
  // current block at each byte end, or at block end the pending block before a coincident strobe.
  always_comb begin
    w_byteValid = 1'b0;
    w_byteData  = 8'h00;
    if (!r_active) begin
      w_byteValid = encrypted_data_state;
      w_byteData  = blockByte(w_inBlock, 4'd0);
    end else if (w_byteDone) begin
      if (!w_lastByte) begin
        w_byteValid = 1'b1;
        w_byteData  = blockByte(r_block, r_byteIdx + 4'd1);
      end else if (r_pendValid) begin
        w_byteValid = 1'b1;
        w_byteData  = blockByte(r_pend, 4'd0);
      end else begin
        w_byteValid = encrypted_data_state;
        w_byteData  = blockByte(w_inBlock, 4'd0);
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_txByte (
    .clk           (clk),
    .rst           (rst),
    .i_byteValid   (w_byteValid),
    .i_byte        (w_byteData),
    .o_tx          (tx),
    .o_byteDone    (w_byteDone),
    .o_byteDoneNext(w_byteDoneNext)
  );

  // Block sequencing and pending slot: a block-end cycle frees a slot, so a strobe there never
  // overruns; otherwise a strobe with both the line and the pending slot occupied is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_block     <= '0;
      r_pend      <= '0;
      r_pendValid <= 1'b0;
      r_active    <= 1'b0;
      r_byteIdx   <= '0;
      r_busy      <= 1'b0;
      r_txDone    <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_txDone  <= r_active && w_byteDoneNext && w_lastByte;
      r_overrun <= 1'b0;
      if (!r_active) begin
        if (encrypted_data_state) begin
          r_block   <= w_inBlock;
          r_active  <= 1'b1;
          r_byteIdx <= '0;
          r_busy    <= 1'b1;
        end
      end else begin
        if (w_byteDone) begin
          r_byteIdx <= r_byteIdx + 4'd1;
        end
        if (w_blockEnd) begin
          if (r_pendValid) begin
            r_block     <= r_pend;
            r_pendValid <= encrypted_data_state;
            if (encrypted_data_state) begin
              r_pend <= w_inBlock;
            end
          end else if (encrypted_data_state) begin
            r_block <= w_inBlock;
          end else begin
            r_active <= 1'b0;
            r_busy   <= 1'b0;
          end
        end else if (encrypted_data_state) begin
          if (!r_pendValid) begin
            r_pend      <= w_inBlock;
            r_pendValid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule
